// File: rtl/debounce_pkg.sv
// Shared types and helpers for the switch debouncer: channel FSM state
// encoding, counter width calculation and the default settle time.
package debounce_pkg;

    // Per-channel debounce FSM states; the PEND_* states are waiting for
    // a new value to persist long enough to be accepted.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_t;

    // 10 ms at a 100 MHz board clock.
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

    // Width of the persistence counter: clog2 of the settle time, never
    // narrower than one bit so the degenerate 1-cycle case still builds.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bundle between the board pins/consumer side (master) and the
// debouncer (slave): raw inputs in, clean levels and edge pulses out.
interface switch_debouncer_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] sw_in;
    logic [NUM_CH-1:0] sw_level;
    logic [NUM_CH-1:0] sw_rise;
    logic [NUM_CH-1:0] sw_fall;
    logic              sw_any_change;

    modport master (
        output sw_in,
        input  sw_level,
        input  sw_rise,
        input  sw_fall,
        input  sw_any_change
    );

    modport slave (
        input  sw_in,
        output sw_level,
        output sw_rise,
        output sw_fall,
        output sw_any_change
    );
endinterface

// File: rtl/debounce_channel.sv
// One debounced switch channel: synchronizer chain, four-state FSM with a
// persistence counter, and registered one-cycle rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int             CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    deb_state_t             state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;

    // Plain flop chain to resolve metastability; only the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    // State, counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= STABLE_LO;
            cnt_reg   <= '0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // Next state: a differing value must persist STABLE_CYCLES samples; any
    // return to the old level drops back to stable. Pulses fire on accept.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            STABLE_LO: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next = STABLE_HI;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = PEND_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_next = STABLE_LO;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = STABLE_HI;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next = STABLE_LO;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = PEND_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_next = STABLE_HI;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = STABLE_LO;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = STABLE_LO;
            end
        endcase
    end

    // Level stays at the old value while a change is still pending.
    assign level = (state_reg == STABLE_HI) || (state_reg == PEND_LO);
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Debouncer for all board switch channels: one independent channel per
// input plus a combined any-change strobe.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    switch_debouncer_if.slave  bus
);
    logic [NUM_CH-1:0] level_vec;
    logic [NUM_CH-1:0] rise_vec;
    logic [NUM_CH-1:0] fall_vec;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_channel (
                .clk   (clk),
                .rst   (rst),
                .sw_in (bus.sw_in[gi]),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi]),
                .fall  (fall_vec[gi])
            );
        end
    endgenerate

    assign bus.sw_level      = level_vec;
    assign bus.sw_rise       = rise_vec;
    assign bus.sw_fall       = fall_vec;
    // Pulses are registered, so this strobe is clean and lasts one cycle.
    assign bus.sw_any_change = |{rise_vec, fall_vec};

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two instances (settle time 4 and 1) driven by
// directed scenarios and random toggling, compared every cycle against a
// sliding-window reference model.
module tb_switch_debouncer;
    localparam int NCH  = 2;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_debouncer_if #(.NUM_CH(NCH)) swif0 ();
    switch_debouncer_if #(.NUM_CH(NCH)) swif1 ();

    switch_debouncer #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (swif0)
    );

    switch_debouncer #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (swif1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observed-pulse tallies for scenario-level checks.
    int rise0, fall0, both_fall, rise1, fall1;

    // Reference model: the input is delayed SYNC samples, then the level
    // flips whenever the last STABLE samples all differ from it.
    logic [SYNC-1:0] m_sync  [2][NCH];
    logic [7:0]      m_hist  [2][NCH];
    int              m_fill  [2][NCH];
    logic            m_level [2][NCH];
    logic            m_rise  [2][NCH];
    logic            m_fall  [2][NCH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                m_sync[d][c]  = '0;
                m_hist[d][c]  = '0;
                m_fill[d][c]  = 0;
                m_level[d][c] = 1'b0;
                m_rise[d][c]  = 1'b0;
                m_fall[d][c]  = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input logic [NCH-1:0] in0, input logic [NCH-1:0] in1, input logic r);
        if (r) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            int stab;
            stab = (d == 0) ? 4 : 1;
            for (int c = 0; c < NCH; c++) begin
                logic x, s, flip;
                x = (d == 0) ? in0[c] : in1[c];
                s = m_sync[d][c][SYNC-1];
                m_sync[d][c] = {m_sync[d][c][SYNC-2:0], x};
                m_hist[d][c] = {m_hist[d][c][6:0], s};
                if (m_fill[d][c] < 8) m_fill[d][c]++;
                m_rise[d][c] = 1'b0;
                m_fall[d][c] = 1'b0;
                flip = (m_fill[d][c] >= stab);
                for (int j = 0; j < stab; j++) begin
                    if (m_hist[d][c][j] == m_level[d][c]) flip = 1'b0;
                end
                if (flip) begin
                    m_level[d][c] = ~m_level[d][c];
                    if (m_level[d][c]) m_rise[d][c] = 1'b1;
                    else               m_fall[d][c] = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, model the rising edge, compare
    // shortly after it.
    task automatic step(input logic [NCH-1:0] in0, input logic [NCH-1:0] in1, input logic r, input string tag);
        logic [NCH-1:0] e_lvl, e_rise, e_fall;
        @(negedge clk);
        swif0.sw_in = in0;
        swif1.sw_in = in1;
        rst         = r;
        @(posedge clk);
        model_edge(in0, in1, r);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                e_lvl[c]  = m_level[d][c];
                e_rise[c] = m_rise[d][c];
                e_fall[c] = m_fall[d][c];
            end
            if (d == 0) begin
                check_val($sformatf("%s dut0 level", tag), 32'(swif0.sw_level), 32'(e_lvl));
                check_val($sformatf("%s dut0 rise", tag),  32'(swif0.sw_rise),  32'(e_rise));
                check_val($sformatf("%s dut0 fall", tag),  32'(swif0.sw_fall),  32'(e_fall));
                check_val($sformatf("%s dut0 any", tag),   32'(swif0.sw_any_change), 32'(|{e_rise, e_fall}));
            end else begin
                check_val($sformatf("%s dut1 level", tag), 32'(swif1.sw_level), 32'(e_lvl));
                check_val($sformatf("%s dut1 rise", tag),  32'(swif1.sw_rise),  32'(e_rise));
                check_val($sformatf("%s dut1 fall", tag),  32'(swif1.sw_fall),  32'(e_fall));
                check_val($sformatf("%s dut1 any", tag),   32'(swif1.sw_any_change), 32'(|{e_rise, e_fall}));
            end
        end
        rise0 += int'(swif0.sw_rise[0]);
        fall0 += int'(swif0.sw_fall[0]);
        if (swif0.sw_fall === 2'b11) both_fall++;
        rise1 += int'(swif1.sw_rise[0]);
        fall1 += int'(swif1.sw_fall[0]);
    endtask

    task automatic clear_tally();
        rise0 = 0; fall0 = 0; both_fall = 0; rise1 = 0; fall1 = 0;
    endtask

    initial begin
        logic [NCH-1:0] r0, r1;
        logic           rr;
        logic [4:0]     toggles;

        swif0.sw_in = '0;
        swif1.sw_in = '0;
        model_reset();
        clear_tally();

        repeat (3) step(2'b00, 2'b00, 1'b1, "reset");
        repeat (3) step(2'b00, 2'b00, 1'b0, "idle");
        $display("txn reset/idle done, checks=%0d", n_checks);

        clear_tally();
        repeat (10) step(2'b01, 2'b00, 1'b0, "press");
        check_val("press rise count", 32'(rise0), 32'd1);
        $display("txn clean press ch0, rises=%0d", rise0);

        clear_tally();
        repeat (10) step(2'b00, 2'b00, 1'b0, "release");
        check_val("release fall count", 32'(fall0), 32'd1);
        $display("txn release ch0, falls=%0d", fall0);

        clear_tally();
        repeat (3) step(2'b01, 2'b00, 1'b0, "bounce");
        repeat (8) step(2'b00, 2'b00, 1'b0, "bounce");
        check_val("bounce pulse count", 32'(rise0 + fall0), 32'd0);
        $display("txn bounce rejection, pulses=%0d", rise0 + fall0);

        clear_tally();
        toggles = 5'b10101;
        for (int i = 0; i < 5; i++) step({1'b0, toggles[i]}, 2'b00, 1'b0, "settle");
        repeat (8) step(2'b01, 2'b00, 1'b0, "settle");
        check_val("settle rise count", 32'(rise0), 32'd1);
        $display("txn bounce then settle, rises=%0d", rise0);

        repeat (10) step(2'b00, 2'b00, 1'b0, "drop");

        clear_tally();
        repeat (10) step(2'b11, 2'b00, 1'b0, "both");
        repeat (10) step(2'b00, 2'b00, 1'b0, "both");
        check_val("simultaneous fall", 32'(both_fall), 32'd1);
        $display("txn simultaneous release, dual-fall cycles=%0d", both_fall);

        clear_tally();
        repeat (4) step(2'b01, 2'b00, 1'b0, "midrst");
        repeat (2) step(2'b01, 2'b00, 1'b1, "midrst");
        repeat (8) step(2'b01, 2'b00, 1'b0, "midrst");
        check_val("midrst rise count", 32'(rise0), 32'd1);
        $display("txn reset mid-pending, rises=%0d", rise0);
        repeat (10) step(2'b00, 2'b00, 1'b0, "drop");

        clear_tally();
        step(2'b00, 2'b01, 1'b0, "degen");
        repeat (5) step(2'b00, 2'b00, 1'b0, "degen");
        check_val("degen rise count", 32'(rise1), 32'd1);
        check_val("degen fall count", 32'(fall1), 32'd1);
        $display("txn single-cycle pulse on fast channel, rises=%0d falls=%0d", rise1, fall1);

        r0 = '0;
        r1 = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(4, 0) == 0) r0[c] = ~r0[c];
                if ($urandom_range(3, 0) == 0) r1[c] = ~r1[c];
            end
            rr = ($urandom_range(299, 0) == 0);
            step(r0, r1, rr, "random");
        end
        $display("txn random stimulus 3000 cycles done, checks=%0d", n_checks);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
